clb_param: RTL and testbench

CLB_PARAM -- requirements
Module: clb_param

---
 rtl/clb_param.sv | 163 ++++++++++++++++
 tb/tb_clb_param.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/clb_param.sv
`default_nettype none
// ============================================================================
// Module   : clb_param
// Purpose  : Parameterised configurable logic block. It contains NUM_LUT
//            LUT_K-input look-up tables, each with an optional output
//            flip-flop. The configuration is loaded through a serial shift
//            chain. A small FSM tracks the IDLE -> LOAD -> RUN lifecycle.
// Ports    : k         - clock; all state updates on the rising edge
//            rst       - synchronous active-high reset
//            shift_en  - configuration shift enable
//            shift_i   - configuration serial data in
//            shift_o   - configuration serial data out (cfg[0]), for chaining
//            in        - LUT inputs; LUT j uses in[j*LUT_K +: LUT_K]
//            ce        - flip-flop clock enable
//            out       - block outputs, one per LUT
//            cfg_done  - high while the block is in RUN
//            carry_i   - carry chain input      (CLB_CARRY_EN only)
//            carry_o   - carry chain output     (CLB_CARRY_EN only)
// Config   : define CLB_CARRY_EN to add the carry chain and the per-LUT
//            cy_sel configuration bit.
// Revision : 1.0 - initial release
// ============================================================================
module clb_param #(
    parameter int LUT_K   = 4,
    parameter int NUM_LUT = 2
) (
    input  logic                       k,
    input  logic                       rst,
    input  logic                       shift_en,
    input  logic                       shift_i,
    output logic                       shift_o,
    input  logic [NUM_LUT*LUT_K-1:0]   in,
    input  logic                       ce,
    output logic [NUM_LUT-1:0]         out,
    output logic                       cfg_done
`ifdef CLB_CARRY_EN
    ,
    input  logic                       carry_i,
    output logic                       carry_o
`endif
);

    // Per-LUT slice layout: [C_TT-1:0] truth table, C_TT reg_sel,
    // C_TT+1 ff_init, C_TT+2 cy_sel (carry build only).
    localparam int C_TT = 1 << LUT_K;
`ifdef CLB_CARRY_EN
    localparam int C_W  = C_TT + 3;
`else
    localparam int C_W  = C_TT + 2;
`endif
    localparam int C_CFG_LEN = NUM_LUT * C_W;
    localparam int C_CW      = $clog2(C_CFG_LEN + 1);

    localparam logic [C_CW-1:0] C_CNT_FULL = C_CW'(C_CFG_LEN);
    localparam logic [C_CW-1:0] C_CNT_ONE  = C_CW'(1);

    localparam logic [1:0] C_ST_IDLE = 2'd0;
    localparam logic [1:0] C_ST_LOAD = 2'd1;
    localparam logic [1:0] C_ST_RUN  = 2'd2;

    logic [1:0]           r_state;
    logic [C_CFG_LEN-1:0] r_cfg;
    logic [C_CW-1:0]      r_count;
    logic [NUM_LUT-1:0]   r_q;

    logic [C_CFG_LEN-1:0] w_shifted;
    logic [NUM_LUT-1:0]   w_lut;
    logic [NUM_LUT-1:0]   w_reg_sel;
    logic [NUM_LUT-1:0]   w_ff_init;
    logic [C_TT-1:0]      w_tt;
    logic [LUT_K-1:0]     w_idx;
    logic                 w_run;
`ifdef CLB_CARRY_EN
    logic                 w_cy;
`endif

    // New bits enter at the top so the first bit shifted ends up in cfg[0].
    assign w_shifted = {shift_i, r_cfg[C_CFG_LEN-1:1]};
    assign w_run     = (r_state == C_ST_RUN);
    assign cfg_done  = w_run;
    assign shift_o   = r_cfg[0];

    // LUT evaluation. With the carry chain, the ripple runs from LUT 0
    // upwards, so the chain value is carried in a loop temporary rather than
    // fed back through w_lut.
    always_comb begin
        w_lut = '0;
        w_tt  = '0;
        w_idx = '0;
`ifdef CLB_CARRY_EN
        w_cy  = carry_i;
`endif
        for (int j = 0; j < NUM_LUT; j++) begin
            w_tt  = r_cfg[j*C_W +: C_TT];
            w_idx = in[j*LUT_K +: LUT_K];
`ifdef CLB_CARRY_EN
            if (r_cfg[j*C_W + C_TT + 2]) begin
                w_idx[0] = w_cy;
            end
            w_cy = w_tt[w_idx];
`endif
            w_lut[j] = w_tt[w_idx];
        end
    end

    generate
        for (genvar j = 0; j < NUM_LUT; j++) begin : g_lut
            assign w_reg_sel[j] = r_cfg[j*C_W + C_TT];
            assign w_ff_init[j] = r_cfg[j*C_W + C_TT + 1];
            assign out[j]       = w_run & (w_reg_sel[j] ? r_q[j] : w_lut[j]);
        end
    endgenerate

`ifdef CLB_CARRY_EN
    assign carry_o = w_run & w_lut[NUM_LUT-1];
`endif

    // Lifecycle FSM, shift chain, load counter and LUT flip-flops.
    always_ff @(posedge k) begin
        if (rst) begin
            r_state <= C_ST_IDLE;
            r_cfg   <= '0;
            r_count <= '0;
            r_q     <= '0;
        end else begin
            case (r_state)
                C_ST_IDLE: begin
                    if (shift_en) begin
                        r_cfg   <= w_shifted;
                        r_count <= C_CNT_ONE;
                        r_state <= C_ST_LOAD;
                    end
                end
                C_ST_LOAD: begin
                    if (shift_en) begin
                        r_cfg <= w_shifted;
                        // Saturate: surplus bits keep shifting, count stays full.
                        if (r_count != C_CNT_FULL) begin
                            r_count <= r_count + C_CNT_ONE;
                        end
                    end else if (r_count == C_CNT_FULL) begin
                        r_state <= C_ST_RUN;
                        r_q     <= w_ff_init;
                    end
                end
                C_ST_RUN: begin
                    if (shift_en) begin
                        r_cfg   <= w_shifted;
                        r_count <= C_CNT_ONE;
                        r_state <= C_ST_LOAD;
                    end else if (ce) begin
                        r_q <= w_lut;
                    end
                end
                default: begin
                    r_state <= C_ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_clb_param.sv
`default_nettype none
// ============================================================================
// Module   : tb_clb_param
// Purpose  : Self-checking bench for clb_param at default parameters
//            (LUT_K=4, NUM_LUT=2, carry chain disabled). Expected outputs
//            come from a field-level model of the configured block.
// Revision : 1.0 - initial release
// ============================================================================
module tb_clb_param;

    localparam int K = 4;
    localparam int N = 2;
    localparam int W = 18;
    localparam int L = 36;

    logic         k = 1'b0;
    logic         rst = 1'b0;
    logic         shift_en = 1'b0;
    logic         shift_i = 1'b0;
    logic         ce = 1'b0;
    logic [7:0]   in = 8'h00;
    logic [1:0]   out;
    logic         shift_o;
    logic         cfg_done;

    int tests_run = 0;
    int tests_failed = 0;

    clb_param #(.LUT_K(K), .NUM_LUT(N)) dut (
        .k        (k),
        .rst      (rst),
        .shift_en (shift_en),
        .shift_i  (shift_i),
        .shift_o  (shift_o),
        .in       (in),
        .ce       (ce),
        .out      (out),
        .cfg_done (cfg_done)
    );

    always #5 k = ~k;

    // Build a configuration image from per-LUT fields.
    function automatic logic [L-1:0] make_image(
        input logic [15:0] tt0, input logic rs0, input logic fi0,
        input logic [15:0] tt1, input logic rs1, input logic fi1);
        return {fi1, rs1, tt1, fi0, rs0, tt0};
    endfunction

    // Truth-table lookup of LUT j for input vector v.
    function automatic logic lut_val(input logic [L-1:0] img, input int j,
                                     input logic [7:0] v);
        logic [15:0] tt;
        logic [3:0]  idx;
        tt  = img[j*W +: 16];
        idx = v[j*K +: K];
        return tt[idx];
    endfunction

    // Expected block output for a configured block in RUN.
    function automatic logic [1:0] model_out(input logic [L-1:0] img,
                                             input logic [1:0] q,
                                             input logic [7:0] v);
        logic [1:0] o;
        for (int j = 0; j < N; j++) begin
            o[j] = img[j*W + 16] ? q[j] : lut_val(img, j, v);
        end
        return o;
    endfunction

    function automatic logic [1:0] init_q(input logic [L-1:0] img);
        return {img[W + 17], img[17]};
    endfunction

    task automatic step();
        @(posedge k);
        #1;
    endtask

    task automatic shift_bits(input logic [L-1:0] img, input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            shift_en = 1'b1;
            shift_i  = img[i];
            step();
        end
        shift_en = 1'b0;
    endtask

    task automatic enter_run();
        shift_en = 1'b0;
        step();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        shift_en = 1'b1;
        shift_i = 1'b1;
        step();
        rst = 1'b0;
        shift_en = 1'b0;
        shift_i = 1'b0;
        in = 8'hFF;
        #1;
        tests_run++;
        if (out !== 2'b00) begin
            tests_failed++;
            $display("FAIL reset_out: got %b expected 00", out);
        end
        tests_run++;
        if (cfg_done !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_cfg_done: got %b expected 0", cfg_done);
        end
        tests_run++;
        if (shift_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_shift_o: got %b expected 0", shift_o);
        end
        step();
        tests_run++;
        if (cfg_done !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_idle_hold: got %b expected 0", cfg_done);
        end
    endtask

    task automatic test_comb();
        logic [L-1:0] img;
        img = make_image(16'h8000, 1'b0, 1'b0, 16'h6996, 1'b0, 1'b0);
        shift_bits(img, 0, L-1);
        tests_run++;
        if (cfg_done !== 1'b0) begin
            tests_failed++;
            $display("FAIL comb_before_run: got %b expected 0", cfg_done);
        end
        enter_run();
        tests_run++;
        if (cfg_done !== 1'b1) begin
            tests_failed++;
            $display("FAIL comb_cfg_done: got %b expected 1", cfg_done);
        end
        in = 8'hFF;
        #1;
        tests_run++;
        if (out !== 2'b01) begin
            tests_failed++;
            $display("FAIL comb_in_ff: got %b expected 01", out);
        end
        in = 8'h1F;
        #1;
        tests_run++;
        if (out !== 2'b11) begin
            tests_failed++;
            $display("FAIL comb_in_1f: got %b expected 11", out);
        end
    endtask

    task automatic test_registered();
        logic [L-1:0] img;
        img = make_image(16'hAAAA, 1'b1, 1'b1, 16'h0000, 1'b0, 1'b0);
        ce = 1'b0;
        shift_bits(img, 0, L-1);
        in = 8'h00;
        ce = 1'b1;
        enter_run();
        tests_run++;
        if (out[0] !== 1'b1) begin
            tests_failed++;
            $display("FAIL reg_ff_init: got %b expected 1", out[0]);
        end
        step();
        tests_run++;
        if (out[0] !== 1'b0) begin
            tests_failed++;
            $display("FAIL reg_capture: got %b expected 0", out[0]);
        end
        ce = 1'b0;
        in = 8'h01;
        step();
        tests_run++;
        if (out[0] !== 1'b0) begin
            tests_failed++;
            $display("FAIL reg_ce_hold: got %b expected 0", out[0]);
        end
        ce = 1'b1;
        step();
        tests_run++;
        if (out[0] !== 1'b1) begin
            tests_failed++;
            $display("FAIL reg_ce_update: got %b expected 1", out[0]);
        end
        ce = 1'b0;
    endtask

    task automatic test_partial();
        logic [L-1:0] img;
        img = make_image(16'h8000, 1'b0, 1'b0, 16'h6996, 1'b0, 1'b0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        in = 8'hFF;
        shift_bits(img, 0, 19);
        for (int c = 0; c < 10; c++) begin
            step();
            tests_run++;
            if (cfg_done !== 1'b0 || out !== 2'b00) begin
                tests_failed++;
                $display("FAIL partial_hold[%0d]: got cfg_done=%b out=%b expected 0/00",
                         c, cfg_done, out);
            end
        end
        shift_bits(img, 20, L-1);
        enter_run();
        tests_run++;
        if (cfg_done !== 1'b1 || out !== 2'b01) begin
            tests_failed++;
            $display("FAIL partial_complete: got cfg_done=%b out=%b expected 1/01",
                     cfg_done, out);
        end
    endtask

    task automatic test_reconfig();
        logic [L-1:0] old_img;
        logic [L-1:0] img;
        logic [1:0]   exp;
        old_img = make_image(16'h8000, 1'b0, 1'b0, 16'h6996, 1'b0, 1'b0);
        img = make_image(16'($urandom), 1'b0, 1'($urandom), 16'($urandom), 1'b0, 1'($urandom));
        in = 8'hFF;
        shift_en = 1'b1;
        shift_i = img[0];
        step();
        tests_run++;
        if (cfg_done !== 1'b0 || out !== 2'b00) begin
            tests_failed++;
            $display("FAIL reconfig_leave_run: got cfg_done=%b out=%b expected 0/00",
                     cfg_done, out);
        end
        tests_run++;
        if (shift_o !== old_img[1]) begin
            tests_failed++;
            $display("FAIL reconfig_shift_o: got %b expected %b", shift_o, old_img[1]);
        end
        shift_bits(img, 1, L-1);
        enter_run();
        for (int c = 0; c < 6; c++) begin
            in = 8'($urandom);
            #1;
            exp = model_out(img, 2'b00, in);
            tests_run++;
            if (out !== exp) begin
                tests_failed++;
                $display("FAIL reconfig_out[%0d]: in=%h got %b expected %b", c, in, out, exp);
            end
        end
    endtask

    task automatic test_reset_midload();
        logic [L-1:0] junk;
        logic [L-1:0] img;
        junk = {4'($urandom), 32'($urandom)};
        img = make_image(16'h8000, 1'b0, 1'b0, 16'h6996, 1'b0, 1'b0);
        shift_bits(junk, 0, 9);
        rst = 1'b1;
        shift_en = 1'b1;
        step();
        rst = 1'b0;
        shift_en = 1'b0;
        step();
        tests_run++;
        if (cfg_done !== 1'b0 || out !== 2'b00 || shift_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL midload_reset: got cfg_done=%b out=%b shift_o=%b expected 0/00/0",
                     cfg_done, out, shift_o);
        end
        shift_bits(img, 0, L-1);
        enter_run();
        in = 8'hFF;
        #1;
        tests_run++;
        if (cfg_done !== 1'b1 || out !== 2'b01) begin
            tests_failed++;
            $display("FAIL midload_reload_ff: got cfg_done=%b out=%b expected 1/01",
                     cfg_done, out);
        end
        in = 8'h1F;
        #1;
        tests_run++;
        if (out !== 2'b11) begin
            tests_failed++;
            $display("FAIL midload_reload_1f: got %b expected 11", out);
        end
    endtask

    // Random images, preceded by surplus junk bits that must shift out,
    // then random input/ce traffic compared against the field-level model.
    task automatic test_random();
        logic [L-1:0] img;
        logic [L-1:0] junk;
        logic [1:0]   m_q;
        logic [1:0]   exp;
        int           extra;
        for (int t = 0; t < 4; t++) begin
            img = {4'($urandom), 32'($urandom)};
            junk = {4'($urandom), 32'($urandom)};
            extra = int'($urandom_range(0, 5));
            if (extra > 0) begin
                shift_bits(junk, 0, extra - 1);
            end
            shift_bits(img, 0, L-1);
            ce = 1'($urandom);
            enter_run();
            m_q = init_q(img);
            tests_run++;
            if (shift_o !== img[0]) begin
                tests_failed++;
                $display("FAIL random_shift_o[%0d]: got %b expected %b", t, shift_o, img[0]);
            end
            for (int c = 0; c < 20; c++) begin
                in = 8'($urandom);
                ce = 1'($urandom);
                #1;
                exp = model_out(img, m_q, in);
                tests_run++;
                if (cfg_done !== 1'b1 || out !== exp) begin
                    tests_failed++;
                    $display("FAIL random_out[%0d.%0d]: in=%h q=%b got %b expected %b",
                             t, c, in, m_q, out, exp);
                end
                step();
                if (ce) begin
                    m_q = {lut_val(img, 1, in), lut_val(img, 0, in)};
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_comb();
        test_registered();
        test_partial();
        test_reconfig();
        test_reset_midload();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
`default_nettype wire
